flash_copy_dma: RTL and testbench

//  Bus-master DMA that copies a block of 32-bit words from the quad-SPI flash window
//  (served by the SPI bus slave) to any bus-addressed memory, e.g. SDRAM at boot.

---
 rtl/flash_copy_dma_pkg.sv | 44 ++++
 rtl/flash_copy_dma_buffer.sv | 40 ++++
 rtl/flash_copy_dma.sv | 219 +++++++++++++++++++++
 tb/tb_flash_copy_dma.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_copy_dma_pkg.sv
// Shared types and constants for the flash-to-memory copy DMA.
package flash_copy_dma_pkg;

  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned WORD_W    = 32;

  localparam logic [3:0] CMD_WR_SRC    = 4'd0;
  localparam logic [3:0] CMD_WR_DST    = 4'd1;
  localparam logic [3:0] CMD_WR_COUNT  = 4'd2;
  localparam logic [3:0] CMD_START     = 4'd3;
  localparam logic [3:0] CMD_RD_STATUS = 4'd4;
  localparam logic [3:0] CMD_RD_REMAIN = 4'd5;
  localparam logic [3:0] CMD_ABORT     = 4'd6;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_REQ   = 4'd1,
    RD_BEGIN = 4'd2,
    RD_DATA  = 4'd3,
    WR_REQ   = 4'd4,
    WR_BEGIN = 4'd5,
    WR_DATA  = 4'd6,
    WR_END   = 4'd7,
    DONE     = 4'd8
  } state_e;

  typedef struct packed {
    logic              request;
    logic              beginTx;
    logic              readNotWrite;
    logic              endTx;
    logic              dataValid;
    logic [3:0]        byteEnables;
    logic [7:0]        burstSize;
    logic [WORD_W-1:0] addressData;
  } busOut_t;

  // True in every phase where this master owns the bus after a grant.
  function automatic logic ownsBus(input state_e s);
    return (s == RD_BEGIN) || (s == RD_DATA) || (s == WR_BEGIN) ||
           (s == WR_DATA) || (s == WR_END);
  endfunction

endpackage

// File: rtl/flash_copy_dma_buffer.sv
// Single-burst word buffer; pointers clear at each burst start so nothing spans bursts.
module flash_copy_dma_buffer
  import flash_copy_dma_pkg::*;
#(
  parameter int unsigned depth = BURST_MAX
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic [WORD_W-1:0]         pushData,
  input  logic                      pop,
  output logic [WORD_W-1:0]         headData,
  output logic [$clog2(depth):0]    count
);

  localparam int unsigned ptrW = $clog2(depth);

  logic [WORD_W-1:0] mem [depth];
  logic [ptrW:0]     wrPtr;
  logic [ptrW:0]     rdPtr;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (ptrW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (ptrW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr[ptrW-1:0]] <= pushData;
  end

  assign headData = mem[rdPtr[ptrW-1:0]];
  assign count    = wrPtr - rdPtr;

endmodule

// File: rtl/flash_copy_dma.sv
// Bus-master DMA copying words from the quad-SPI flash window to bus memory,
// configured and polled through a custom instruction.
module flash_copy_dma
  import flash_copy_dma_pkg::*;
#(
  parameter logic [7:0]  customInstructionNr = 8'd1,
  parameter logic [31:0] flashBase           = 32'h04000000,
  parameter int unsigned maxBurstWords       = BURST_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciDataA,
  input  logic [31:0] ciDataB,
  input  logic        ciStart,
  input  logic        ciCke,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        readNotWriteOut,
  output logic        endTransactionOut,
  output logic        dataValidOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  input  logic        busyIn
);

  localparam int unsigned cntW = $clog2(maxBurstWords) + 1;

  state_e            state;
  state_e            stateNext;
  busOut_t           busQ;
  busOut_t           busD;
  logic [21:0]       srcOffset;
  logic [29:0]       dstAddr;
  logic [15:0]       wordCount;
  logic              errFlag;
  logic              abortPending;
  logic [cntW-1:0]   wrCnt;
  logic [cntW-1:0]   burstLen;
  logic [cntW-1:0]   bufCount;
  logic [WORD_W-1:0] bufHead;
  logic [31:0]       rdAddr;
  logic [31:0]       wrAddr;
  logic [15:0]       remainAfter;
  logic [3:0]        ciSub;
  logic              busy;
  logic              startC;
  logic              acceptC;
  logic              pushC;
  logic              popC;
  logic              clearC;
  logic              errC;
  logic              unusedBits;

  assign unusedBits = ^{ciDataA[1:0], ciDataB[31:4]};

  assign ciSub   = ciDataB[3:0];
  assign ciDone  = ciStart & ciCke & (ciN == customInstructionNr);
  assign busy    = (state != IDLE);
  assign startC  = ciDone && (ciSub == CMD_START) && !busy && (wordCount != 16'd0);
  assign acceptC = busQ.dataValid & ~busyIn;

  assign burstLen    = (wordCount > 16'(maxBurstWords)) ? cntW'(maxBurstWords) : cntW'(wordCount);
  assign rdAddr      = flashBase + 32'({srcOffset, 2'b00});
  assign wrAddr      = {dstAddr, 2'b00};
  assign remainAfter = wordCount - 16'(burstLen);

  always_comb begin
    ciResult = '0;
    if (ciDone) begin
      case (ciSub)
        CMD_RD_STATUS: ciResult = {30'd0, errFlag, busy};
        CMD_RD_REMAIN: ciResult = {16'd0, wordCount};
        default:       ciResult = '0;
      endcase
    end
  end

  flash_copy_dma_buffer #(.depth(maxBurstWords)) buffer (
    .clock    (clock),
    .reset    (reset),
    .clear    (clearC),
    .push     (pushC),
    .pushData (addressDataIn),
    .pop      (popC),
    .headData (bufHead),
    .count    (bufCount)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state plus next value of every registered bus output.
  always_comb begin
    stateNext = state;
    pushC     = 1'b0;
    popC      = 1'b0;
    clearC    = 1'b0;
    errC      = 1'b0;
    busD      = '0;

    case (state)
      IDLE: if (startC) stateNext = RD_REQ;
      RD_REQ: begin
        if (abortPending) stateNext = IDLE;
        else if (transactionGranted) begin
          clearC    = 1'b1;
          stateNext = RD_BEGIN;
        end
      end
      RD_BEGIN: stateNext = RD_DATA;
      RD_DATA: begin
        if (dataValidIn) begin
          if (bufCount < burstLen) pushC = 1'b1;
          else                     errC  = 1'b1;
        end
        // A short burst is as fatal as a bus error.
        if (endTransactionIn && !errC) begin
          if ((bufCount + cntW'(pushC)) != burstLen) errC = 1'b1;
          else                                       stateNext = WR_REQ;
        end
      end
      WR_REQ: begin
        if (abortPending)            stateNext = IDLE;
        else if (transactionGranted) stateNext = WR_BEGIN;
      end
      WR_BEGIN: stateNext = WR_DATA;
      WR_DATA: if (acceptC && (wrCnt == burstLen - cntW'(1))) stateNext = WR_END;
      WR_END: begin
        if (remainAfter == 16'd0) stateNext = DONE;
        else if (abortPending)    stateNext = IDLE;
        else                      stateNext = RD_REQ;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    if (ownsBus(state) && busErrorIn) errC = 1'b1;
    if (errC) begin
      stateNext = IDLE;
      pushC     = 1'b0;
    end

    popC = (stateNext == WR_DATA) && ((state == WR_BEGIN) || acceptC);

    busD.request      = (stateNext == RD_REQ) || (stateNext == WR_REQ);
    busD.beginTx      = (stateNext == RD_BEGIN) || (stateNext == WR_BEGIN);
    busD.readNotWrite = (stateNext == RD_BEGIN);
    busD.endTx        = (stateNext == WR_END);
    busD.dataValid    = (stateNext == WR_DATA);
    busD.byteEnables  = ownsBus(stateNext) ? 4'hF : 4'h0;
    busD.burstSize    = busD.beginTx ? 8'(burstLen - cntW'(1)) : 8'd0;
    case (stateNext)
      RD_BEGIN: busD.addressData = rdAddr;
      WR_BEGIN: busD.addressData = wrAddr;
      WR_DATA:  busD.addressData = popC ? bufHead : busQ.addressData;
      default:  busD.addressData = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busQ         <= '0;
      srcOffset    <= '0;
      dstAddr      <= '0;
      wordCount    <= '0;
      errFlag      <= 1'b0;
      abortPending <= 1'b0;
      wrCnt        <= '0;
    end else begin
      busQ <= busD;

      if (ciDone && !busy) begin
        case (ciSub)
          CMD_WR_SRC:   srcOffset <= ciDataA[23:2];
          CMD_WR_DST:   dstAddr   <= ciDataA[31:2];
          CMD_WR_COUNT: wordCount <= ciDataA[15:0];
          default: ;
        endcase
      end

      if (startC) errFlag <= 1'b0;
      if (errC)   errFlag <= 1'b1;

      if (ciDone && (ciSub == CMD_ABORT) && busy) abortPending <= 1'b1;
      if (stateNext == IDLE)                      abortPending <= 1'b0;

      if (state == WR_BEGIN)               wrCnt <= '0;
      else if (state == WR_DATA && acceptC) wrCnt <= wrCnt + cntW'(1);

      // Advance both windows once a whole burst has been written.
      if (state == WR_END && !errC) begin
        srcOffset <= srcOffset + 22'(burstLen);
        dstAddr   <= dstAddr + 30'(burstLen);
        wordCount <= remainAfter;
      end
    end
  end

  assign requestTransaction  = busQ.request;
  assign beginTransactionOut = busQ.beginTx;
  assign readNotWriteOut     = busQ.readNotWrite;
  assign endTransactionOut   = busQ.endTx;
  assign dataValidOut        = busQ.dataValid;
  assign byteEnablesOut      = busQ.byteEnables;
  assign burstSizeOut        = busQ.burstSize;
  assign addressDataOut      = busQ.addressData;

endmodule

// File: tb/tb_flash_copy_dma.sv
// Directed bench: bus slave model feeds read bursts, scoreboard queue checks write bursts.
module tb_flash_copy_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciDataA = 32'd0;
  logic [31:0] ciDataB = 32'd0;
  logic        ciStart = 1'b0;
  logic        ciCke = 1'b0;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        requestTransaction;
  logic        transactionGranted = 1'b0;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic        endTransactionOut;
  logic        dataValidOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn = 32'd0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        busErrorIn = 1'b0;
  logic        busyIn = 1'b0;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] expWords[$];
  logic [31:0] r;

  always #5 clock = ~clock;

  flash_copy_dma dut (
    .clock               (clock),
    .reset               (reset),
    .ciN                 (ciN),
    .ciDataA             (ciDataA),
    .ciDataB             (ciDataB),
    .ciStart             (ciStart),
    .ciCke               (ciCke),
    .ciDone              (ciDone),
    .ciResult            (ciResult),
    .requestTransaction  (requestTransaction),
    .transactionGranted  (transactionGranted),
    .beginTransactionOut (beginTransactionOut),
    .addressDataOut      (addressDataOut),
    .readNotWriteOut     (readNotWriteOut),
    .endTransactionOut   (endTransactionOut),
    .dataValidOut        (dataValidOut),
    .byteEnablesOut      (byteEnablesOut),
    .burstSizeOut        (burstSizeOut),
    .addressDataIn       (addressDataIn),
    .dataValidIn         (dataValidIn),
    .endTransactionIn    (endTransactionIn),
    .busErrorIn          (busErrorIn),
    .busyIn              (busyIn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] busCtl();
    return {15'd0, requestTransaction, beginTransactionOut, readNotWriteOut,
            endTransactionOut, dataValidOut, byteEnablesOut, burstSizeOut};
  endfunction

  function automatic logic [31:0] ctlWord(input bit req, input bit bgn, input bit rnw,
                                          input bit ends, input bit dv, input logic [3:0] be,
                                          input logic [7:0] bs);
    return {15'd0, req, bgn, rnw, ends, dv, be, bs};
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic ciOp(input logic [3:0] cmd, input logic [31:0] a, output logic [31:0] res);
    ciN = 8'd1; ciDataA = a; ciDataB = {28'd0, cmd}; ciStart = 1'b1; ciCke = 1'b1;
    #1 res = ciResult;
    @(negedge clock);
    ciStart = 1'b0; ciCke = 1'b0; ciDataA = '0; ciDataB = '0;
  endtask

  task automatic ciWr(input logic [3:0] cmd, input logic [31:0] a);
    logic [31:0] dummy;
    ciOp(cmd, a, dummy);
  endtask

  task automatic waitReq(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (requestTransaction) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, " reqSeen"}, 32'(ok), 32'd1);
  endtask

  task automatic serveRead(input string tag, input logic [31:0] addr, input int n, input int errAt);
    bit ok;
    logic [31:0] w;
    waitReq(tag, ok);
    if (!ok) return;
    transactionGranted = 1'b1;
    @(negedge clock);
    transactionGranted = 1'b0;
    check({tag, " rdBegin"}, busCtl(), ctlWord(0, 1, 1, 0, 0, 4'hF, 8'(n - 1)));
    check({tag, " rdAddr"}, addressDataOut, addr);
    @(negedge clock);
    for (int i = 0; i < n; i++) begin
      if (i == errAt) begin
        busErrorIn = 1'b1;
        @(negedge clock);
        busErrorIn = 1'b0;
        return;
      end
      w = $urandom;
      dataValidIn = 1'b1; addressDataIn = w; endTransactionIn = (i == n - 1);
      expWords.push_back(w);
      @(negedge clock);
      dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b0;
    end
  endtask

  task automatic serveWrite(input string tag, input logic [31:0] addr, input int n,
                            input int stallAt, input int stallCycles);
    bit ok;
    logic [31:0] exp;
    waitReq(tag, ok);
    if (!ok) return;
    transactionGranted = 1'b1;
    @(negedge clock);
    transactionGranted = 1'b0;
    check({tag, " wrBegin"}, busCtl(), ctlWord(0, 1, 0, 0, 0, 4'hF, 8'(n - 1)));
    check({tag, " wrAddr"}, addressDataOut, addr);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check({tag, " sbHasWord"}, 32'(expWords.size() > 0), 32'd1);
      exp = (expWords.size() > 0) ? expWords.pop_front() : 32'hBAD0BAD0;
      check({tag, " wrValid"}, 32'(dataValidOut), 32'd1);
      check({tag, " wrData"}, addressDataOut, exp);
      if (k == stallAt) begin
        busyIn = 1'b1;
        for (int s = 0; s < stallCycles; s++) begin
          @(negedge clock);
          check({tag, " heldData"}, addressDataOut, exp);
        end
        busyIn = 1'b0;
      end
    end
    @(negedge clock);
    check({tag, " wrEnd"}, busCtl(), ctlWord(0, 0, 0, 1, 0, 4'hF, 8'd0));
  endtask

  initial begin
    bit sawReq;

    repeat (3) @(negedge clock);
    check("rstBus", busCtl(), 32'd0);
    check("rstAddr", addressDataOut, 32'd0);
    reset = 1'b0;
    ciOp(4'd4, 32'd0, r);
    check("rstStatus", r, 32'd0);

    ciN = 8'd2; ciStart = 1'b1; ciCke = 1'b1; ciDataB = 32'd4;
    #1 check("ciOtherNr", {31'd0, ciDone}, 32'd0);
    ciN = 8'd0; ciStart = 1'b0; ciCke = 1'b0; ciDataB = '0;
    @(negedge clock);

    ciWr(4'd3, 32'd0);
    ciOp(4'd4, 32'd0, r);
    check("startCount0", r, 32'd0);

    // Single 4-word copy.
    ciWr(4'd0, 32'h400);
    ciWr(4'd1, 32'h8000);
    ciWr(4'd2, 32'd4);
    ciOp(4'd5, 32'd0, r);
    check("t1Remain", r, 32'd4);
    ciWr(4'd3, 32'd0);
    serveRead("t1", 32'h04000400, 4, -1);
    serveWrite("t1", 32'h00008000, 4, -1, 0);
    repeat (2) @(negedge clock);
    ciOp(4'd4, 32'd0, r);
    check("t1Status", r, 32'd0);

    // 40 words in bursts of 16/16/8, with a write stall and ignored CI writes.
    ciWr(4'd0, 32'h1000);
    ciWr(4'd1, 32'h10000);
    ciWr(4'd2, 32'd40);
    ciWr(4'd3, 32'd0);
    for (int b = 0; b < 3; b++) begin
      int n;
      n = (b < 2) ? 16 : 8;
      serveRead("t2", 32'h04001000 + 32'(64 * b), n, -1);
      if (b == 0) begin
        ciWr(4'd2, 32'd99);
        ciWr(4'd3, 32'd0);
        ciWr(4'd0, 32'h8888);
        ciWr(4'd1, 32'h4444);
        ciOp(4'd5, 32'd0, r);
        check("t5RemainKept", r, 32'd40);
        ciOp(4'd4, 32'd0, r);
        check("t5StatusBusy", r, 32'd1);
      end
      serveWrite("t2", 32'h00010000 + 32'(64 * b), n, (b == 1) ? 2 : -1, 3);
    end
    repeat (2) @(negedge clock);
    ciOp(4'd5, 32'd0, r);
    check("t2Remain", r, 32'd0);
    ciOp(4'd4, 32'd0, r);
    check("t2Status", r, 32'd0);

    // Bus error on the fifth read word.
    ciWr(4'd0, 32'h0);
    ciWr(4'd1, 32'h100);
    ciWr(4'd2, 32'd8);
    ciWr(4'd3, 32'd0);
    serveRead("t4", 32'h04000000, 8, 4);
    check("t4BusOff", busCtl(), 32'd0);
    check("t4AddrOff", addressDataOut, 32'd0);
    expWords.delete();
    ciOp(4'd4, 32'd0, r);
    check("t4Status", r, 32'd2);
    sawReq = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (requestTransaction) sawReq = 1'b1;
    end
    check("t4NoWrite", 32'(sawReq), 32'd0);
    ciOp(4'd5, 32'd0, r);
    check("t4Remain", r, 32'd8);

    // Reset asserted while write data is on the bus.
    ciWr(4'd3, 32'd0);
    serveRead("t6", 32'h04000000, 8, -1);
    ciOp(4'd4, 32'd0, r);
    check("t6ErrCleared", r, 32'd1);
    begin
      bit ok;
      waitReq("t6", ok);
      transactionGranted = 1'b1;
      @(negedge clock);
      transactionGranted = 1'b0;
      @(negedge clock);
      check("t6WrValid", 32'(dataValidOut), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("t6RstBus", busCtl(), 32'd0);
      check("t6RstAddr", addressDataOut, 32'd0);
      reset = 1'b0;
    end
    expWords.delete();
    ciOp(4'd4, 32'd0, r);
    check("t6Status", r, 32'd0);
    ciWr(4'd0, 32'h40);
    ciWr(4'd1, 32'h200);
    ciWr(4'd2, 32'd2);
    ciWr(4'd3, 32'd0);
    serveRead("t6b", 32'h04000040, 2, -1);
    serveWrite("t6b", 32'h00000200, 2, -1, 0);
    repeat (2) @(negedge clock);
    ciOp(4'd4, 32'd0, r);
    check("t6bStatus", r, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
